// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the iterative MIPS multiply/divide unit.
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  localparam int unsigned HiloWeLo = 0;
  localparam int unsigned HiloWeHi = 1;

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Pipeline-side request/response bundle of the multiply/divide unit.
interface mips_muldiv_unit_if
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic            start;
  md_op_e          op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic [1:0]      hilo_we;
  logic [XLEN-1:0] hilo_wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, kill, hilo_we, hilo_wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, kill, hilo_we, hilo_wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] work_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] work_o,
  output logic [XLEN-1:0]   opnd_o
);
  logic [XLEN:0]   sum;
  logic [XLEN:0]   upper;
  logic [XLEN-1:0] diff;

  always_comb begin
    opnd_o = opnd_i;
    sum    = {1'b0, work_i[2*XLEN-1:XLEN]} + (work_i[0] ? {1'b0, opnd_i} : '0);
    // Partial remainder after the left shift; needs XLEN+1 bits before the trial subtract.
    upper  = work_i[2*XLEN-1:XLEN-1];
    diff   = upper[XLEN-1:0] - opnd_i;
    if (div_i) begin
      if (upper >= {1'b0, opnd_i}) begin
        work_o = {diff, work_i[XLEN-2:0], 1'b1};
      end else begin
        work_o = {upper[XLEN-1:0], work_i[XLEN-2:0], 1'b0};
      end
    end else begin
      work_o = {sum, work_i[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO and kill support.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input logic                clk_i,
  input logic                rst_ni,
  mips_muldiv_unit_if.slave  bus_io
);
  localparam int unsigned Iters = XLEN / UNROLL;
  localparam int unsigned CntW  = $clog2(XLEN);

  md_state_e         state_q;
  md_op_e            op_q;
  logic [CntW-1:0]   cnt_q;
  logic [2*XLEN-1:0] work_q;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_res_q, neg_rem_q, dbz_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   hi_q, lo_q;

  logic              accept, is_div, is_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs, quo, rem, fix_hi, fix_lo;
  logic [2*XLEN-1:0] prod;

  logic [2*XLEN-1:0] work_chain [UNROLL+1];
  logic [XLEN-1:0]   opnd_chain [UNROLL+1];

  assign work_chain[0] = work_q;
  assign opnd_chain[0] = opnd_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .div_i  (is_div),
      .work_i (work_chain[g]),
      .opnd_i (opnd_chain[g]),
      .work_o (work_chain[g+1]),
      .opnd_o (opnd_chain[g+1])
    );
  end

  always_comb begin
    accept    = (state_q == MD_IDLE) && bus_io.start && !bus_io.kill;
    is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
    is_signed = (bus_io.op == MD_MULT) || (bus_io.op == MD_DIV);
    a_neg     = is_signed && bus_io.a[XLEN-1];
    b_neg     = is_signed && bus_io.b[XLEN-1];
    a_abs     = a_neg ? -bus_io.a : bus_io.a;
    b_abs     = b_neg ? -bus_io.b : bus_io.b;
    // Divide by zero leaves quotient all ones and remainder |a|; re-signing the
    // remainder with a's sign restores the original a for HI.
    prod      = neg_res_q ? -work_q : work_q;
    quo       = (neg_res_q && !dbz_q) ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
    rem       = neg_rem_q ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];
    fix_hi    = is_div ? rem : prod[2*XLEN-1:XLEN];
    fix_lo    = is_div ? quo : prod[XLEN-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      work_q    <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MD_IDLE: begin
          if (accept) begin
            state_q   <= MD_CALC;
            busy_q    <= 1'b1;
            op_q      <= bus_io.op;
            cnt_q     <= CntW'(Iters - 1);
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dbz_q     <= (bus_io.b == '0);
            if (bus_io.op == MD_DIV || bus_io.op == MD_DIVU) begin
              work_q <= {{XLEN{1'b0}}, a_abs};
              opnd_q <= b_abs;
            end else begin
              work_q <= {{XLEN{1'b0}}, b_abs};
              opnd_q <= a_abs;
            end
          end else begin
            if (bus_io.hilo_we[HiloWeHi]) hi_q <= bus_io.hilo_wdata;
            if (bus_io.hilo_we[HiloWeLo]) lo_q <= bus_io.hilo_wdata;
          end
        end
        MD_CALC: begin
          if (bus_io.kill) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
          end else begin
            work_q <= work_chain[UNROLL];
            opnd_q <= opnd_chain[UNROLL];
            if (cnt_q == '0) begin
              state_q <= MD_FIX;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
        end
        MD_FIX: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          if (!bus_io.kill) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;
  assign bus_io.hi   = hi_q;
  assign bus_io.lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: default build plus an UNROLL=4 build.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit_if #(.XLEN(32)) md0 ();
  mips_muldiv_unit_if #(.XLEN(32)) md4 ();

  mips_muldiv_unit #(.XLEN(32), .UNROLL(1)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (md0)
  );

  mips_muldiv_unit #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (md4)
  );

  task automatic drive(input bit sel, input logic s, input md_op_e op, input logic [31:0] a,
                       input logic [31:0] b);
    if (sel) begin
      md4.start = s; md4.op = op; md4.a = a; md4.b = b;
    end else begin
      md0.start = s; md0.op = op; md0.a = a; md0.b = b;
    end
  endtask

  task automatic issue(input bit sel, input md_op_e op, input logic [31:0] a,
                       input logic [31:0] b);
    @(posedge clk); #1;
    drive(sel, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, op, a, b);
  endtask

  task automatic wait_idle(input bit sel, output int n, output logic d_now, output logic d_next);
    logic bz;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bz = sel ? md4.busy : md0.busy;
      if (!bz) break;
      n++;
    end
    d_now = sel ? md4.done : md0.done;
    @(negedge clk);
    d_next = sel ? md4.done : md0.done;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks += 4;
    if (md0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", md0.busy); end
    if (md0.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", md0.done); end
    if (md0.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", md0.hi); end
    if (md0.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", md0.lo); end
  endtask

  task automatic run_table(input bit sel, input int lat, input vec_t v[$]);
    int   n;
    logic dn, dx;
    logic [31:0] hi, lo;
    for (int i = 0; i < v.size(); i++) begin
      issue(sel, v[i].op, v[i].a, v[i].b);
      wait_idle(sel, n, dn, dx);
      hi = sel ? md4.hi : md0.hi;
      lo = sel ? md4.lo : md0.lo;
      n_checks += 5;
      if (hi !== v[i].hi) begin
        n_fail++; $display("FAIL u%0d_vec%0d_hi got %h want %h", sel ? 4 : 1, i, hi, v[i].hi);
      end
      if (lo !== v[i].lo) begin
        n_fail++; $display("FAIL u%0d_vec%0d_lo got %h want %h", sel ? 4 : 1, i, lo, v[i].lo);
      end
      if (n !== lat) begin
        n_fail++; $display("FAIL u%0d_vec%0d_latency got %0d want %0d", sel ? 4 : 1, i, n, lat);
      end
      if (dn !== 1'b1) begin
        n_fail++; $display("FAIL u%0d_vec%0d_done got %b want 1", sel ? 4 : 1, i, dn);
      end
      if (dx !== 1'b0) begin
        n_fail++; $display("FAIL u%0d_vec%0d_done_pulse got %b want 0", sel ? 4 : 1, i, dx);
      end
    end
  endtask

  task automatic test_muldiv;
    vec_t v[$];
    v.push_back('{MD_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    v.push_back('{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    v.push_back('{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    v.push_back('{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    v.push_back('{MD_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF});
    v.push_back('{MD_DIV,   32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF});
    v.push_back('{MD_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2});
    v.push_back('{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E});
    v.push_back('{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    v.push_back('{MD_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780});
    v.push_back('{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF});
    run_table(1'b0, 33, v);
  endtask

  task automatic test_unroll4;
    vec_t v[$];
    v.push_back('{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
    v.push_back('{MD_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    v.push_back('{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    v.push_back('{MD_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF});
    run_table(1'b1, 9, v);
  endtask

  task automatic test_kill_reset;
    logic seen_done;
    @(posedge clk); #1;
    md0.hilo_we = 2'b11; md0.hilo_wdata = 32'h77;
    @(posedge clk); #1;
    md0.hilo_we = 2'b00;
    @(negedge clk);
    n_checks += 2;
    if (md0.hi !== 32'h77) begin n_fail++; $display("FAIL mt_both_hi got %h want 77", md0.hi); end
    if (md0.lo !== 32'h77) begin n_fail++; $display("FAIL mt_both_lo got %h want 77", md0.lo); end
    @(posedge clk); #1;
    md0.hilo_we = 2'b10; md0.hilo_wdata = 32'hAAAA;
    @(posedge clk); #1;
    md0.hilo_we = 2'b01; md0.hilo_wdata = 32'h5555;
    @(posedge clk); #1;
    md0.hilo_we = 2'b00;
    @(negedge clk);
    n_checks += 2;
    if (md0.hi !== 32'hAAAA) begin n_fail++; $display("FAIL mthi got %h want aaaa", md0.hi); end
    if (md0.lo !== 32'h5555) begin n_fail++; $display("FAIL mtlo got %h want 5555", md0.lo); end
    // kill in IDLE must swallow the start
    @(posedge clk); #1;
    drive(1'b0, 1'b1, MD_MULT, 32'd7, 32'd3); md0.kill = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, MD_MULT, 32'd7, 32'd3); md0.kill = 1'b0;
    n_checks++;
    if (md0.busy !== 1'b0) begin n_fail++; $display("FAIL kill_idle_busy got %b want 0", md0.busy); end
    issue(1'b0, MD_MULT, 32'd7, 32'd3);
    repeat (9) @(posedge clk);
    #1 md0.kill = 1'b1;
    @(posedge clk); #1;
    md0.kill = 1'b0;
    seen_done = md0.done;
    n_checks++;
    if (md0.busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got %b want 0", md0.busy); end
    repeat (3) begin
      @(negedge clk);
      seen_done = seen_done | md0.done;
    end
    n_checks += 3;
    if (seen_done !== 1'b0) begin n_fail++; $display("FAIL kill_done got %b want 0", seen_done); end
    if (md0.hi !== 32'hAAAA) begin n_fail++; $display("FAIL kill_hi got %h want aaaa", md0.hi); end
    if (md0.lo !== 32'h5555) begin n_fail++; $display("FAIL kill_lo got %h want 5555", md0.lo); end
    issue(1'b0, MD_MULT, 32'd7, 32'd3);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks += 4;
    if (md0.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", md0.busy); end
    if (md0.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", md0.done); end
    if (md0.hi !== 32'h0) begin n_fail++; $display("FAIL rst_hi got %h want 0", md0.hi); end
    if (md0.lo !== 32'h0) begin n_fail++; $display("FAIL rst_lo got %h want 0", md0.lo); end
  endtask

  task automatic test_back_to_back;
    int   n;
    logic dn, dx, found;
    issue(1'b0, MD_MULTU, 32'd5, 32'd6);
    drive(1'b0, 1'b1, MD_DIVU, 32'd1, 32'd1);
    md0.hilo_we = 2'b11; md0.hilo_wdata = 32'hDEAD;
    repeat (20) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, MD_DIVU, 32'd1, 32'd1);
    md0.hilo_we = 2'b00;
    wait_idle(1'b0, n, dn, dx);
    n_checks += 4;
    if (n !== 13) begin n_fail++; $display("FAIL ignore_latency got %0d want 13", n); end
    if (md0.hi !== 32'h0) begin n_fail++; $display("FAIL ignore_hi got %h want 0", md0.hi); end
    if (md0.lo !== 32'd30) begin n_fail++; $display("FAIL ignore_lo got %h want 1e", md0.lo); end
    if (dn !== 1'b1) begin n_fail++; $display("FAIL ignore_done got %b want 1", dn); end
    issue(1'b0, MD_MULTU, 32'd9, 32'd9);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (md0.done) begin found = 1'b1; break; end
    end
    n_checks += 2;
    if (found !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got %b want 1", found); end
    if (md0.lo !== 32'd81) begin n_fail++; $display("FAIL b2b_first_lo got %h want 51", md0.lo); end
    drive(1'b0, 1'b1, MD_MULT, 32'd2, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, MD_MULT, 32'd2, 32'hFFFF_FFFD);
    n_checks++;
    if (md0.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", md0.busy); end
    wait_idle(1'b0, n, dn, dx);
    n_checks += 4;
    if (n !== 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", n); end
    if (md0.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_hi got %h want ffffffff", md0.hi); end
    if (md0.lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL b2b_lo got %h want fffffffa", md0.lo); end
    if (dn !== 1'b1 || dx !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done_pulse got %b%b want 10", dn, dx);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, MD_MULT, 32'h0, 32'h0);
    drive(1'b1, 1'b0, MD_MULT, 32'h0, 32'h0);
    md0.kill = 1'b0; md0.hilo_we = 2'b00; md0.hilo_wdata = 32'h0;
    md4.kill = 1'b0; md4.hilo_we = 2'b00; md4.hilo_wdata = 32'h0;
    repeat (2) @(posedge clk);
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_muldiv();
    test_unroll4();
    test_kill_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline. It executes MULT, MULTU, DIV and DIVU over several cycles alongside the EX stage, and serves MFHI/MFLO reads and MTHI/MTLO writes. It exposes a busy signal that the stall logic uses to hold IF/ID and the PC. It also accepts a kill input so a flushed instruction never updates HI/LO.

## Interface
- XLEN, 32, operand width; even, ≥8
- UNROLL, 1, radix-2 iterations per clock; must divide XLEN (1, 2, 4, 8)
- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- start_i  in  1  issue request; sampled only in IDLE
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
- a_i, b_i  in  XLEN  rs / rt operands (post-forwarding)
- kill_i  in  1  abort in-flight operation (EX flush)
- hilo_we_i  in  2  bit1 MTHI, bit0 MTLO write enables
- hilo_wdata_i  in  XLEN  MTHI/MTLO data
- busy_o  out  1  operation in flight
- done_o  out  1  one-cycle pulse after HI/LO update
- hi_o, lo_o  out  XLEN  HI/LO register contents

## Operation
- The FSM has three states: IDLE, CALC and FIX.
- IDLE, start_i=1, kill_i=0:
  - Latch op.
  - Latch |a|, |b| for signed ops (raw for unsigned).
  - Record result sign(s).
  - Record div-by-zero (b==0).
  - Set iteration counter to XLEN/UNROLL−1.
  - Go to CALC.
- CALC:
  - Each edge performs UNROLL shift-add steps (multiply) or UNROLL restoring shift-subtract steps (divide) on a 2·XLEN working register.
  - When the counter is 0, go to FIX; otherwise decrement.
- FIX:
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the sign of a.
  - Write HI/LO. Multiply gives HI = upper product, LO = lower product. Divide gives LO = quotient, HI = remainder.
  - Assert done_o next cycle.
  - Go to IDLE.
- Divide by zero: LO = all ones, HI = a_i (original signed value). Full latency is still taken.
- Signed overflow (−2^(XLEN−1) / −1): LO = −2^(XLEN−1), HI = 0.
- kill_i in CALC/FIX: go to IDLE next edge. HI/LO are unchanged and no done_o is produced. kill_i in IDLE suppresses start_i.
- start_i while busy_o=1 is ignored. The pipeline must stall on busy_o.
- hilo_we_i:
  - Honoured only in IDLE with no accepted start in the same cycle.
  - Ignored while busy (the MTHI/MTLO stalls behind busy_o).
  - Both bits may be set together.
- hi_o/lo_o are registered outputs. Intermediate CALC values never appear on them.

## Timing
- Reset (Reset=0 at an edge) from any state gives: IDLE, busy_o=0, done_o=0, hi_o=lo_o=0, counter=0. This applies mid-operation too; the operation is discarded.
- Start accepted at edge k:
  - busy_o=1 from k+1 through the FIX cycle, i.e. XLEN/UNROLL+1 cycles.
  - HI/LO updated at edge k+XLEN/UNROLL+1.
  - done_o=1 and busy_o=0 in the following cycle.
- Back-to-back: start_i asserted in the done_o cycle is accepted.
- Latency for the default build is 33 busy cycles. With UNROLL=4 it is 9.
- A MTHI/MTLO write takes effect at the next edge and is visible on hi_o/lo_o in the following cycle.

## Structure
- Package mips_muldiv_pkg holds:
  - the op encoding enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - the state enum (MD_IDLE, MD_CALC, MD_FIX)
  - the hilo_we bit position constants
- Sub-module muldiv_step is one combinational radix-2 iteration: a mode input, and working register plus divisor/multiplicand in and out. It is instantiated UNROLL times in a generate chain.
- Top level holds the FSM, counter, sign/exception flags, working register and HI/LO.

## Test plan
- MULT a=7, b=0xFFFFFFFD (−3) → after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, done_o single-cycle pulse.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234, still 33 busy cycles.
- Preload via MTHI=0xAAAA, MTLO=0x5555. Start MULT, assert kill_i in cycle 10 → busy_o=0 next cycle, no done_o, HI/LO still 0xAAAA/0x5555. Repeat with Reset=0 mid-CALC → all outputs 0.
- start_i and hilo_we_i held during busy → both ignored, and the original result is written. A second start in the done_o cycle is accepted and busy rises the next cycle.
- UNROLL=4 build: MULTU 0x10000 × 0x10000 → HI=1, LO=0 with 9 busy cycles. Randomised signed/unsigned ops are checked against a reference model.
